// File: rtl/train_ctrl_pkg.sv
// Shared encodings and helpers for the solver training-loop controller.
package train_ctrl_pkg;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_EVAL    = 3'd2;
    localparam logic [2:0] ST_COMPARE = 3'd3;
    localparam logic [2:0] ST_SAVE    = 3'd4;
    localparam logic [2:0] ST_UPDATE  = 3'd5;
    localparam logic [2:0] ST_DRAIN   = 3'd6;
    localparam logic [2:0] ST_DONE    = 3'd7;

    // Default datapath widths; error width carries guard bits
    localparam int unsigned DEF_BIT_WIDTH  = 32;
    localparam int unsigned DEF_EXTRA_BITS = 2;
    localparam int unsigned DEF_EW         = DEF_BIT_WIDTH + DEF_EXTRA_BITS;

    // "No error seen yet" marker for the default error width
    localparam logic [DEF_EW-1:0] ERR_ONES = '1;

    // Bits needed to hold values 0..max_val (at least one bit)
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/phase_counter.sv
// Loadable down-counter timing each FSM phase; terminal marks the last cycle.
module phase_counter #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             hold,
    input  logic [WIDTH-1:0] load_value,
    output logic             terminal
);

    logic [WIDTH-1:0] count;

    // Hold freezes the count; load wins over decrement; stop at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (!hold) begin
            if (load) begin
                count <= load_value;
            end else if (count != '0) begin
                count <= count - WIDTH'(1);
            end
        end
    end

    assign terminal = (count == WIDTH'(1));

endmodule

// File: rtl/training_sequencer.sv
// Training-loop controller: load/eval/compare epochs, keep best weights, replay them.
module training_sequencer
    import train_ctrl_pkg::*;
#(
    parameter int unsigned BIT_WIDTH    = DEF_BIT_WIDTH,
    parameter int unsigned EXTRA_BITS   = DEF_EXTRA_BITS,
    parameter int unsigned NUM_UNKNOWNS = 2,
    parameter int unsigned PIPE_LAT     = 4,
    parameter int unsigned MAX_EPOCHS   = 1024,
    parameter int unsigned TOL          = 0
) (
    input  logic                                  CLK,
    input  logic                                  RESET,
    input  logic                                  start,
    input  logic                                  stall_in,
    input  logic [BIT_WIDTH+EXTRA_BITS-1:0]       l2_error,
    output logic                                  initial_read_flag,
    output logic                                  training_mode,
    output logic                                  wr_best,
    output logic                                  rd_best,
    output logic                                  finish,
    output logic                                  stall_out,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  converged,
    output logic [cnt_width(MAX_EPOCHS)-1:0]      epoch_count,
    output logic [BIT_WIDTH+EXTRA_BITS-1:0]       best_error
);

    localparam int unsigned EW      = BIT_WIDTH + EXTRA_BITS;
    localparam int unsigned CW      = cnt_width(MAX_EPOCHS);
    localparam int unsigned PHASE_MAX = (NUM_UNKNOWNS > PIPE_LAT) ? NUM_UNKNOWNS : PIPE_LAT;
    localparam int unsigned PW      = cnt_width(PHASE_MAX);

    localparam logic [EW-1:0] TOL_V    = EW'(TOL);
    localparam logic [CW-1:0] MAX_V    = CW'(MAX_EPOCHS);
    localparam logic [PW-1:0] LEN_VEC  = PW'(NUM_UNKNOWNS);
    localparam logic [PW-1:0] LEN_PIPE = PW'(PIPE_LAT);
    localparam logic [PW-1:0] LEN_ONE  = PW'(1);

    logic [2:0]    state;
    logic [2:0]    state_next;
    logic [EW-1:0] err_q;
    logic [EW-1:0] err_next;
    logic [EW-1:0] best_next;
    logic [CW-1:0] epoch_next;
    logic [CW-1:0] epoch_inc;
    logic          irf_next;
    logic          conv_next;
    logic          term_go;
    logic [EW-1:0] chk_err;
    logic [CW-1:0] chk_epoch;
    logic          phase_load;
    logic [PW-1:0] phase_len;
    logic          phase_last;

    phase_counter #(
        .WIDTH (PW)
    ) u_phase (
        .clk        (CLK),
        .rst        (RESET),
        .load       (phase_load),
        .hold       (stall_in),
        .load_value (phase_len),
        .terminal   (phase_last)
    );

    // Next-state, scoreboard and flag update logic; stall freezes everything
    always_comb begin
        state_next = state;
        err_next   = err_q;
        best_next  = best_error;
        epoch_next = epoch_count;
        irf_next   = initial_read_flag;
        conv_next  = converged;
        term_go    = 1'b0;
        chk_err    = err_q;
        chk_epoch  = epoch_count;
        epoch_inc  = (epoch_count < MAX_V) ? (epoch_count + CW'(1)) : epoch_count;

        if (!stall_in) begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state_next = ST_LOAD;
                        epoch_next = '0;
                        best_next  = '1;
                        conv_next  = 1'b0;
                        irf_next   = 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (phase_last) state_next = ST_EVAL;
                end
                ST_EVAL: begin
                    if (phase_last) state_next = ST_COMPARE;
                end
                ST_COMPARE: begin
                    err_next   = l2_error;
                    epoch_next = epoch_inc;
                    if (l2_error < best_error) begin
                        best_next  = l2_error;
                        state_next = ST_SAVE;
                    end else begin
                        term_go   = 1'b1;
                        chk_err   = l2_error;
                        chk_epoch = epoch_inc;
                    end
                end
                ST_SAVE: begin
                    if (phase_last) begin
                        term_go   = 1'b1;
                        chk_err   = err_q;
                        chk_epoch = epoch_count;
                    end
                end
                ST_UPDATE: begin
                    if (phase_last) begin
                        irf_next   = 1'b0;
                        state_next = ST_LOAD;
                    end
                end
                ST_DRAIN: begin
                    if (phase_last) state_next = ST_DONE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase

            // Termination check: tolerance first, then epoch budget
            if (term_go) begin
                if (chk_err <= TOL_V) begin
                    conv_next  = 1'b1;
                    state_next = ST_DRAIN;
                end else if (chk_epoch == MAX_V) begin
                    state_next = ST_DRAIN;
                end else begin
                    state_next = ST_UPDATE;
                end
            end
        end
    end

    // Phase length loaded on every state entry
    always_comb begin
        phase_load = (state_next != state);
        case (state_next)
            ST_LOAD, ST_SAVE, ST_UPDATE, ST_DRAIN: phase_len = LEN_VEC;
            ST_EVAL:                               phase_len = LEN_PIPE;
            ST_COMPARE, ST_DONE:                   phase_len = LEN_ONE;
            default:                               phase_len = '0;
        endcase
    end

    // State, scoreboard and registered level outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state             <= ST_IDLE;
            err_q             <= '0;
            best_error        <= '1;
            epoch_count       <= '0;
            initial_read_flag <= 1'b0;
            converged         <= 1'b0;
            finish            <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
        end else begin
            state             <= state_next;
            err_q             <= err_next;
            best_error        <= best_next;
            epoch_count       <= epoch_next;
            initial_read_flag <= irf_next;
            converged         <= conv_next;
            finish            <= (state_next == ST_DRAIN);
            busy              <= (state_next != ST_IDLE);
            done              <= (state_next == ST_DONE);
        end
    end

    // Buffer strobes drop in the same cycle a stall is requested
    assign wr_best       = (state == ST_SAVE)   & ~stall_in;
    assign rd_best       = (state == ST_DRAIN)  & ~stall_in;
    assign training_mode = (state == ST_UPDATE) & ~stall_in;
    assign stall_out     = stall_in;

endmodule

// File: tb/tb_training_sequencer.sv
// Directed cycle-by-cycle bench for training_sequencer.
module tb_training_sequencer;
    import train_ctrl_pkg::*;

    localparam int unsigned EW = 34;
    localparam int unsigned CW = 2;

    // Output vector order: irf, training_mode, wr_best, rd_best, finish, busy, done
    localparam logic [6:0] IDLE0  = 7'b0000000;
    localparam logic [6:0] IDLE1  = 7'b1000000;
    localparam logic [6:0] RUN1   = 7'b1000010;
    localparam logic [6:0] RUN0   = 7'b0000010;
    localparam logic [6:0] SAVE1  = 7'b1010010;
    localparam logic [6:0] SAVE0  = 7'b0010010;
    localparam logic [6:0] UPD1   = 7'b1100010;
    localparam logic [6:0] UPD0   = 7'b0100010;
    localparam logic [6:0] DRAIN1 = 7'b1001110;
    localparam logic [6:0] DRAIN0 = 7'b0001110;
    localparam logic [6:0] DONE1  = 7'b1000011;
    localparam logic [6:0] DONE0  = 7'b0000011;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          start;
    logic          stall_in;
    logic [EW-1:0] l2_error;
    logic          initial_read_flag;
    logic          training_mode;
    logic          wr_best;
    logic          rd_best;
    logic          finish;
    logic          stall_out;
    logic          busy;
    logic          done;
    logic          converged;
    logic [CW-1:0] epoch_count;
    logic [EW-1:0] best_error;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    training_sequencer #(
        .BIT_WIDTH    (32),
        .EXTRA_BITS   (2),
        .NUM_UNKNOWNS (2),
        .PIPE_LAT     (4),
        .MAX_EPOCHS   (3),
        .TOL          (10)
    ) dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .start             (start),
        .stall_in          (stall_in),
        .l2_error          (l2_error),
        .initial_read_flag (initial_read_flag),
        .training_mode     (training_mode),
        .wr_best           (wr_best),
        .rd_best           (rd_best),
        .finish            (finish),
        .stall_out         (stall_out),
        .busy              (busy),
        .done              (done),
        .converged         (converged),
        .epoch_count       (epoch_count),
        .best_error        (best_error)
    );

    function automatic logic [6:0] outs();
        return {initial_read_flag, training_mode, wr_best, rd_best, finish, busy, done};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check the output vector for n consecutive cycles, advancing one clock each
    task automatic step(input string tag, input int n, input logic [6:0] exp);
        for (int i = 0; i < n; i++) begin
            #1;
            chk(tag, 64'(outs()), 64'(exp));
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET    = 1'b1;
        start    = 1'b0;
        stall_in = 1'b0;
        l2_error = '0;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        #1;

        // Reset state
        chk("rst_outs", 64'(outs()), 64'(IDLE0));
        chk("rst_best", 64'(best_error), 64'(ERR_ONES));
        chk("rst_epoch", 64'(epoch_count), 64'd0);
        chk("rst_conv", 64'(converged), 64'd0);

        // start with stall held: stays idle
        stall_in = 1'b1;
        start    = 1'b1;
        #1;
        chk("stall_out_hi", 64'(stall_out), 64'd1);
        step("idle_stall", 2, IDLE0);
        start    = 1'b0;
        stall_in = 1'b0;
        #1;
        chk("stall_out_lo", 64'(stall_out), 64'd0);

        // Single-epoch convergence, error 5 <= TOL
        l2_error = EW'(5);
        start = 1'b1;
        step("t1_idle", 1, IDLE0);
        start = 1'b0;
        step("t1_load", 2, RUN1);
        step("t1_eval", 4, RUN1);
        step("t1_cmp", 1, RUN1);
        step("t1_save", 2, SAVE1);
        step("t1_drain", 2, DRAIN1);
        step("t1_done", 1, DONE1);
        step("t1_end", 1, IDLE1);
        chk("t1_conv", 64'(converged), 64'd1);
        chk("t1_epoch", 64'(epoch_count), 64'd1);
        chk("t1_best", 64'(best_error), 64'd5);

        // Budget exhaustion: 100, 50, 70 with three epochs
        l2_error = EW'(100);
        start = 1'b1;
        step("t2_idle", 1, IDLE1);
        start = 1'b0;
        step("t2_load1", 2, RUN1);
        step("t2_eval1", 4, RUN1);
        step("t2_cmp1", 1, RUN1);
        l2_error = EW'(50);
        step("t2_save1", 2, SAVE1);
        step("t2_upd1", 2, UPD1);
        step("t2_load2", 2, RUN0);
        step("t2_eval2", 4, RUN0);
        step("t2_cmp2", 1, RUN0);
        l2_error = EW'(70);
        step("t2_save2", 2, SAVE0);
        step("t2_upd2", 2, UPD0);
        step("t2_load3", 2, RUN0);
        step("t2_eval3", 4, RUN0);
        step("t2_cmp3", 1, RUN0);
        step("t2_drain", 2, DRAIN0);
        step("t2_done", 1, DONE0);
        step("t2_end", 1, IDLE0);
        chk("t2_conv", 64'(converged), 64'd0);
        chk("t2_epoch", 64'(epoch_count), 64'd3);
        chk("t2_best", 64'(best_error), 64'd50);

        // Tie: equal error does not rewrite best weights
        l2_error = EW'(40);
        start = 1'b1;
        step("t3_idle", 1, IDLE0);
        start = 1'b0;
        step("t3_load1", 2, RUN1);
        step("t3_eval1", 4, RUN1);
        step("t3_cmp1", 1, RUN1);
        step("t3_save1", 2, SAVE1);
        step("t3_upd1", 2, UPD1);
        step("t3_load2", 2, RUN0);
        step("t3_eval2", 4, RUN0);
        step("t3_cmp2", 1, RUN0);
        step("t3_upd2", 2, UPD0);
        step("t3_load3", 2, RUN0);
        step("t3_eval3", 4, RUN0);
        step("t3_cmp3", 1, RUN0);
        step("t3_drain", 2, DRAIN0);
        step("t3_done", 1, DONE0);
        chk("t3_best", 64'(best_error), 64'd40);
        chk("t3_epoch", 64'(epoch_count), 64'd3);

        // Stall for three cycles after the first SAVE cycle
        l2_error = EW'(5);
        start = 1'b1;
        step("t4_idle", 1, IDLE0);
        start = 1'b0;
        step("t4_load", 2, RUN1);
        step("t4_eval", 4, RUN1);
        step("t4_cmp", 1, RUN1);
        step("t4_save_a", 1, SAVE1);
        stall_in = 1'b1;
        step("t4_stalled", 3, RUN1);
        stall_in = 1'b0;
        step("t4_save_b", 1, SAVE1);
        step("t4_drain", 2, DRAIN1);
        step("t4_done", 1, DONE1);
        step("t4_end", 1, IDLE1);
        chk("t4_conv", 64'(converged), 64'd1);
        chk("t4_best", 64'(best_error), 64'd5);

        // Abort: start pulse in LOAD ignored, RESET in EVAL returns to idle
        start = 1'b1;
        step("t5_idle", 1, IDLE1);
        start = 1'b0;
        step("t5_load_a", 1, RUN1);
        start = 1'b1;
        step("t5_load_b", 1, RUN1);
        start = 1'b0;
        step("t5_eval", 2, RUN1);
        RESET = 1'b1;
        step("t5_eval_rst", 1, RUN1);
        RESET = 1'b0;
        step("t5_abort", 1, IDLE0);
        chk("t5_best", 64'(best_error), 64'(ERR_ONES));
        chk("t5_epoch", 64'(epoch_count), 64'd0);
        chk("t5_conv", 64'(converged), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/training_sequencer.md
Name: training_sequencer

Overview:
- Top-level controller for the solver training loop.
- Drives the control inputs of the training datapath: initial-guess/buffer select, training-block enable, best-weight buffer write/read, finish flag and stall.
- Each epoch it streams the weight vector through the forward and backward engines and compares the resulting squared error against the best so far.
- It keeps the best weights and runs weight updates until the error converges or the epoch budget is spent. It then replays the best weights.

Parameters:
- BIT_WIDTH, 32, data width of weights/errors before guard bits
- EXTRA_BITS, 2, guard bits; error width EW = BIT_WIDTH+EXTRA_BITS
- NUM_UNKNOWNS, 2, weights per vector = cycles per load/save/update/drain phase
- PIPE_LAT, 4, cycles from last weight loaded to l2_error valid (forward+backward latency)
- MAX_EPOCHS, 1024, maximum number of evaluated epochs (>=1)
- TOL, 0, convergence threshold; converged when l2_error <= TOL (unsigned)

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset
- start  in  1  begin a solve; sampled only in IDLE
- stall_in  in  1  global stall request
- l2_error  in  EW  squared error from backward engine; sampled in COMPARE
- initial_read_flag  out  1  1 = scaler mux selects ROM initial guess
- training_mode  out  1  training-block update enable
- wr_best  out  1  best-weight buffer write enable
- rd_best  out  1  best-weight buffer read enable
- finish  out  1  mux select: 1 = best-weight buffer output
- stall_out  out  1  stall to buffers (= stall_in, combinational)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse in DONE
- converged  out  1  last solve ended on TOL; held until next start
- epoch_count  out  clog2(MAX_EPOCHS+1)  epochs evaluated in current/last solve
- best_error  out  EW  lowest error seen

Behaviour:
- Reset: state IDLE, phase counter 0, all 1-bit outputs 0, epoch_count 0, best_error all ones. Reset mid-operation aborts; IDLE on the next cycle.
- States: IDLE, LOAD, EVAL, COMPARE, SAVE, UPDATE, DRAIN, DONE.
- Phase counter loads NUM_UNKNOWNS or PIPE_LAT on state entry. The state exits when the count hits 1.
- IDLE: start=1 -> LOAD. On that transition: epoch_count=0, best_error=all ones, converged=0, initial_read_flag=1.
- LOAD: NUM_UNKNOWNS cycles -> EVAL.
- EVAL: PIPE_LAT cycles -> COMPARE.
- COMPARE (1 cycle):
  - epoch_count++.
  - Strictly less (l2_error < best_error): best_error<=l2_error -> SAVE.
  - Otherwise -> termination check.
- SAVE: wr_best=1 for NUM_UNKNOWNS cycles -> termination check.
- Termination check, using the COMPARE-sampled error, evaluated in priority order:
  - error <= TOL: converged=1 -> DRAIN.
  - Otherwise, epoch_count == MAX_EPOCHS -> DRAIN.
  - Otherwise -> UPDATE.
- UPDATE: training_mode=1 for NUM_UNKNOWNS cycles. On exit, initial_read_flag is cleared to 0 and held low, then -> LOAD.
- DRAIN: finish=1 and rd_best=1 for NUM_UNKNOWNS cycles -> DONE.
- DONE: done=1 for 1 cycle -> IDLE. finish drops in DONE.
- Stall (stall_in=1):
  - Freezes state, phase counter, epoch_count and best_error.
  - Forces wr_best, rd_best and training_mode to 0.
  - Level outputs (initial_read_flag, finish, busy) hold.
  - Total strobe-high cycles per phase are unchanged.
- Stall during COMPARE delays the sample and increment to the first unstalled cycle.
- start while busy is ignored. start and stall_in together in IDLE: the stall wins.
- Width rules: compare unsigned over EW bits. epoch_count saturates at MAX_EPOCHS.

Decomposition:
- Package train_ctrl_pkg holds the state enum encoding, EW, the epoch counter width function and the all-ones error constant.
- One sub-module, phase_counter: a loadable down-counter with hold (stall) input and terminal flag. Instantiate it once.

Test Plan:
- Reset/idle: assert RESET 2 cycles -> all strobes 0, best_error=0x3_FFFF_FFFF, busy=0; start with stall_in=1 -> stays IDLE.
- Single-epoch convergence, setup NUM_UNKNOWNS=2, PIPE_LAT=4, TOL=10: start at cycle 0, l2_error=5 ->
  - LOAD cycles 1-2 with initial_read_flag=1, EVAL 3-6, COMPARE 7.
  - wr_best at cycles 8-9; rd_best/finish at 10-11; done at 12.
  - converged=1, epoch_count=1, best_error=5.
- Budget exhaustion, setup MAX_EPOCHS=3, TOL=10: errors 100, 50, 70 ->
  - wr_best bursts in epochs 1 and 2 only; UPDATE bursts after epochs 1 and 2.
  - initial_read_flag=0 from the epoch-2 LOAD onward; no UPDATE after epoch 3.
  - best_error=50, converged=0, epoch_count=3.
- Tie: errors 40 then 40 -> only one wr_best burst; best_error=40.
- Stall mid-SAVE: stall_in high for 3 cycles after the first wr_best cycle -> wr_best low during the stall, exactly 2 high cycles total, state resumes in SAVE.
- Abort: RESET during EVAL -> IDLE the next cycle, best_error all ones. start pulsed during LOAD has no effect on sequence timing.
